// File: rtl/fp_norm_pipe_pkg.sv
// Shared definitions for the FPU mantissa normaliser: format widths,
// leading-zero-count width derivation and the result-flag bundle.
package fpu_norm_pkg;

  localparam int SP_WIDTH = 24;
  localparam int SP_EXP_W = 8;
  localparam int DP_WIDTH = 53;
  localparam int DP_EXP_W = 11;

  // Width needed to hold a count of 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  typedef struct packed {
    logic zero;
    logic uflow;
  } norm_flags_t;

endpackage

// File: rtl/fp_norm_pipe_lzc_tree.sv
// Combinational log-depth leading-zero counter; an all-zero input yields WIDTH.
module lzc_tree
  import fpu_norm_pkg::*;
#(
  parameter int WIDTH = SP_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic [WIDTH-1:0] mant_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int L = $clog2(WIDTH);
  localparam int P = 1 << L;

  logic [P-1:0] pad_s;

  // Padding with ones below the LSB makes the padded count equal WIDTH on zero input.
  if (P > WIDTH) begin : g_pad
    assign pad_s = {mant_i, {(P - WIDTH){1'b1}}};
  end else begin : g_nopad
    assign pad_s = mant_i;
  end

  for (genvar g = 1; g <= L; g++) begin : lvl
    localparam int N = P >> g;
    logic [N-1:0]        v;
    logic [N-1:0][g-1:0] c;
    for (genvar k = 0; k < N; k++) begin : node
      if (g == 1) begin : g_leaf
        assign v[k] = pad_s[2*k+1] | pad_s[2*k];
        assign c[k] = ~pad_s[2*k+1];
      end else begin : g_inner
        logic vh_s;
        logic vl_s;
        assign vh_s = lvl[g-1].v[2*k+1];
        assign vl_s = lvl[g-1].v[2*k];
        assign v[k] = vh_s | vl_s;
        assign c[k] = vh_s ? {1'b0, lvl[g-1].c[2*k+1]} : {1'b1, lvl[g-1].c[2*k]};
      end
    end
  end

  assign cnt_o = lvl[L].v[0] ? CNT_W'(lvl[L].c[0]) : CNT_W'(WIDTH);

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage mantissa normaliser with valid/ready on both sides.
// FP_NORM_DENORM_CLAMP_EN: clamp the shift on exponent underflow to form a denormal.
module fp_norm_pipe
  import fpu_norm_pkg::*;
#(
  parameter int WIDTH = SP_WIDTH,
  parameter int EXP_W = SP_EXP_W,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic [CNT_W-1:0] out_lzc,
  output logic             out_zero,
  output logic             out_uflow
);

  localparam int MW = (CNT_W > EXP_W) ? CNT_W : EXP_W;

  logic             s2_adv_s, s1_adv_s;
  logic [CNT_W-1:0] in_lzc_s;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_mant_q, s1_mant_d;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic [CNT_W-1:0] s1_lzc_q, s1_lzc_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_mant_q, out_mant_d;
  logic [EXP_W-1:0] out_exp_q, out_exp_d;
  logic [CNT_W-1:0] out_lzc_q, out_lzc_d;
  norm_flags_t      out_flags_q, out_flags_d;

  logic [MW-1:0]    lzc_ext_s, exp_ext_s, sh_s;
  logic [WIDTH-1:0] res_mant_s;
  logic [EXP_W-1:0] res_exp_s;
  norm_flags_t      res_flags_s;

  assign s2_adv_s = !out_valid_q || out_ready;
  assign s1_adv_s = !s1_valid_q || s2_adv_s;
  assign in_ready = s1_adv_s;

  lzc_tree #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lzc (
    .mant_i(in_mant),
    .cnt_o (in_lzc_s)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mant_d  = s1_mant_q;
    s1_exp_d   = s1_exp_q;
    s1_lzc_d   = s1_lzc_q;
    if (s1_adv_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mant_d = in_mant;
        s1_exp_d  = in_exp;
        s1_lzc_d  = in_lzc_s;
      end else begin
        s1_mant_d = s1_mant_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Zero takes priority over underflow; the wrapped exponent is the default underflow result.
  always_comb begin
    lzc_ext_s         = MW'(s1_lzc_q);
    exp_ext_s         = MW'(s1_exp_q);
    res_flags_s.zero  = (s1_lzc_q == CNT_W'(WIDTH));
    res_flags_s.uflow = !res_flags_s.zero && (lzc_ext_s >= exp_ext_s);
    sh_s              = lzc_ext_s;
    res_exp_s         = s1_exp_q - EXP_W'(s1_lzc_q);
`ifdef FP_NORM_DENORM_CLAMP_EN
    if (res_flags_s.uflow) begin
      sh_s      = (exp_ext_s == {MW{1'b0}}) ? {MW{1'b0}} : exp_ext_s - MW'(1);
      res_exp_s = {EXP_W{1'b0}};
    end else begin
      sh_s = lzc_ext_s;
    end
`endif
    if (res_flags_s.zero) begin
      res_mant_s = {WIDTH{1'b0}};
      res_exp_s  = {EXP_W{1'b0}};
    end else begin
      res_mant_s = s1_mant_q << sh_s;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_mant_d  = out_mant_q;
    out_exp_d   = out_exp_q;
    out_lzc_d   = out_lzc_q;
    out_flags_d = out_flags_q;
    if (s2_adv_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_mant_d  = res_mant_s;
        out_exp_d   = res_exp_s;
        out_lzc_d   = s1_lzc_q;
        out_flags_d = res_flags_s;
      end else begin
        out_mant_d = out_mant_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mant_q   <= {WIDTH{1'b0}};
      s1_exp_q    <= {EXP_W{1'b0}};
      s1_lzc_q    <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_mant_q  <= {WIDTH{1'b0}};
      out_exp_q   <= {EXP_W{1'b0}};
      out_lzc_q   <= {CNT_W{1'b0}};
      out_flags_q <= 2'b00;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mant_q   <= s1_mant_d;
      s1_exp_q    <= s1_exp_d;
      s1_lzc_q    <= s1_lzc_d;
      out_valid_q <= out_valid_d;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      out_lzc_q   <= out_lzc_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;
  assign out_lzc   = out_lzc_q;
  assign out_zero  = out_flags_q.zero;
  assign out_uflow = out_flags_q.uflow;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Scoreboard bench for fp_norm_pipe (WIDTH=24, EXP_W=8); honours FP_NORM_DENORM_CLAMP_EN.
module tb_fp_norm_pipe;

  localparam int WIDTH = 24;
  localparam int EXP_W = 8;
  localparam int CNT_W = 5;
  localparam int RW    = WIDTH + EXP_W + CNT_W + 2;
  localparam int NV    = 8;

  typedef logic [RW-1:0] res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_mant = '0;
  logic [EXP_W-1:0] in_exp = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_mant;
  logic [EXP_W-1:0] out_exp;
  logic [CNT_W-1:0] out_lzc;
  logic             out_zero;
  logic             out_uflow;

  int   checks = 0;
  int   passes = 0;
  res_t sb[$];
  res_t got_s;

  assign got_s = {out_mant, out_exp, out_lzc, out_zero, out_uflow};

  fp_norm_pipe #(.WIDTH(WIDTH), .EXP_W(EXP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
    .out_lzc(out_lzc), .out_zero(out_zero), .out_uflow(out_uflow)
  );

  always #5 clk = ~clk;

  // Directed vectors with hand-derived results {mant, exp, lzc, zero, uflow}.
  logic [WIDTH-1:0] dm [NV] = '{24'h800000, 24'h000001, 24'h000000, 24'h000100,
                                24'h800000, 24'h7fffff, 24'h400000, 24'h000003};
  logic [EXP_W-1:0] de [NV] = '{8'd127, 8'd127, 8'd50, 8'd10, 8'd0, 8'd2, 8'd1, 8'd200};
`ifdef FP_NORM_DENORM_CLAMP_EN
  res_t dr [NV] = '{{24'h800000, 8'd127, 5'd0,  2'b00}, {24'h800000, 8'd104, 5'd23, 2'b00},
                    {24'h000000, 8'd0,   5'd24, 2'b10}, {24'h020000, 8'd0,   5'd15, 2'b01},
                    {24'h800000, 8'd0,   5'd0,  2'b01}, {24'hfffffe, 8'd1,   5'd1,  2'b00},
                    {24'h400000, 8'd0,   5'd1,  2'b01}, {24'hc00000, 8'd178, 5'd22, 2'b00}};
`else
  res_t dr [NV] = '{{24'h800000, 8'd127, 5'd0,  2'b00}, {24'h800000, 8'd104, 5'd23, 2'b00},
                    {24'h000000, 8'd0,   5'd24, 2'b10}, {24'h800000, 8'd251, 5'd15, 2'b01},
                    {24'h800000, 8'd0,   5'd0,  2'b01}, {24'hfffffe, 8'd1,   5'd1,  2'b00},
                    {24'h800000, 8'd0,   5'd1,  2'b01}, {24'hc00000, 8'd178, 5'd22, 2'b00}};
`endif

  function automatic res_t model(input logic [WIDTH-1:0] m, input logic [EXP_W-1:0] e);
    int               lz;
    int               sh;
    logic [WIDTH-1:0] om;
    logic [EXP_W-1:0] oe;
    lz = WIDTH;
    for (int i = 0; i < WIDTH; i++) if (m[i]) lz = WIDTH - 1 - i;
    if (m == '0) return {{WIDTH{1'b0}}, {EXP_W{1'b0}}, CNT_W'(WIDTH), 2'b10};
    if (lz >= int'(e)) begin
`ifdef FP_NORM_DENORM_CLAMP_EN
      sh = (e == '0) ? 0 : int'(e) - 1;
      om = m << sh;
      return {om, {EXP_W{1'b0}}, CNT_W'(lz), 2'b01};
`else
      sh = lz;
      om = m << sh;
      oe = EXP_W'(int'(e) - lz);
      return {om, oe, CNT_W'(lz), 2'b01};
`endif
    end
    om = m << lz;
    oe = EXP_W'(int'(e) - lz);
    return {om, oe, CNT_W'(lz), 2'b00};
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || got_s !== '0) $display("FAIL reset_outputs: got valid=%b res=%h required valid=0 res=0", out_valid, got_s);
    else passes++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
    else passes++;
  endtask

  task automatic test_directed();
    res_t exp_r;
    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mant = dm[v]; in_exp = de[v]; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL dir_in_ready[%0d]: got %b required 1", v, in_ready);
      else passes++;
      sb.push_back(dr[v]);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) $display("FAIL dir_latency_early[%0d]: got out_valid=%b required 0", v, out_valid);
      else passes++;
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) $display("FAIL dir_latency[%0d]: got out_valid=%b required 1", v, out_valid);
      else begin
        exp_r = sb.pop_front();
        if (got_s !== exp_r) $display("FAIL dir_result[%0d]: got %h required %h", v, got_s, exp_r);
        else passes++;
      end
    end
    sb.delete();
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] bm [3] = '{24'h000010, 24'h0f0000, 24'h000000};
    logic [EXP_W-1:0] be [3] = '{8'd100, 8'd5, 8'd33};
    int   sent = 0, got = 0, cyc = 0, stall_checks = 0;
    bit   have_snap = 1'b0;
    res_t snap, exp_r;
    while ((sent < 3 || sb.size() != 0) && cyc < 40) begin
      @(negedge clk);
      in_valid  = (sent < 3);
      in_mant   = (sent < 3) ? bm[sent] : '0;
      in_exp    = (sent < 3) ? be[sent] : '0;
      out_ready = (cyc >= 5);
      #1;
      if (cyc == 2) begin
        checks++;
        if (in_ready !== 1'b0 || sent != 2) $display("FAIL bp_in_ready_fall: got in_ready=%b sent=%0d required 0 and 2", in_ready, sent);
        else passes++;
      end
      if (out_valid && !out_ready) begin
        if (!have_snap) begin
          snap = got_s; have_snap = 1'b1;
        end else begin
          checks++; stall_checks++;
          if (got_s !== snap) $display("FAIL bp_hold: got %h required %h", got_s, snap);
          else passes++;
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) $display("FAIL bp_extra_output: got %h required none", got_s);
        else begin
          exp_r = sb.pop_front(); got++;
          if (got_s !== exp_r) $display("FAIL bp_result: got %h required %h", got_s, exp_r);
          else passes++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_mant, in_exp)); sent++;
      end
      @(posedge clk);
      cyc++;
    end
    checks++;
    if (got != 3 || cyc >= 40 || stall_checks < 2) $display("FAIL bp_drain: got results=%0d stall_checks=%0d cycles=%0d required 3, >=2, <40", got, stall_checks, cyc);
    else passes++;
    sb.delete();
  endtask

  task automatic test_random();
    int   cyc = 0;
    res_t exp_r;
    while ((cyc < 120 || sb.size() != 0) && cyc < 200) begin
      @(negedge clk);
      in_valid  = (cyc < 120) && ($urandom_range(0, 3) != 0);
      in_mant   = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom >> $urandom_range(0, 31));
      in_exp    = ($urandom_range(0, 1) == 0) ? EXP_W'($urandom_range(0, 30)) : EXP_W'($urandom_range(0, 255));
      out_ready = (cyc >= 120) || ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) $display("FAIL rnd_extra_output: got %h required none", got_s);
        else begin
          exp_r = sb.pop_front();
          if (got_s !== exp_r) $display("FAIL rnd_result: got %h required %h", got_s, exp_r);
          else passes++;
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_mant, in_exp));
      @(posedge clk);
      cyc++;
    end
    checks++;
    if (sb.size() != 0) $display("FAIL rnd_drain: got %0d pending required 0", sb.size());
    else passes++;
    sb.delete();
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    res_t exp_r;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_mant = 24'h001234; in_exp = 8'd90;
    @(negedge clk);
    in_mant = 24'h00ff00; in_exp = 8'd60;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL mid_full: got valid=%b in_ready=%b required 1 0", out_valid, in_ready);
    else passes++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || got_s !== '0 || in_ready !== 1'b1) $display("FAIL mid_async_reset: got valid=%b res=%h in_ready=%b required 0 0 1", out_valid, got_s, in_ready);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) $display("FAIL mid_stale[%0d]: got out_valid=%b required 0", i, out_valid);
      else passes++;
    end
    in_valid = 1'b1; in_mant = 24'h000001; in_exp = 8'd127;
    sb.push_back(model(in_mant, in_exp));
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) $display("FAIL mid_new_beat: got out_valid=%b required 1", out_valid);
    else begin
      exp_r = sb.pop_front();
      if (got_s !== exp_r) $display("FAIL mid_new_result: got %h required %h", got_s, exp_r);
      else passes++;
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
